spc_stack_ctrl: RTL and testbench

Pointer and strobe controller for the 32-entry SPC (subroutine return) stack built from 82S21 32x2 RAM parts.
- Owns the 5-bit stack pointer.
- Sequences address, write data, WE_N, LATCH_N and CE to the RAM bank.
- Keeps a registered copy of the top-of-stack for the microsequencer.
- Sits between the sequencer's push/pop requests (upstream) and the 82S21 bank (downstream).

---
 rtl/spc_pkg.sv | 26 ++
 rtl/spc_ptr.sv | 46 ++++
 rtl/spc_stack_ctrl.sv | 159 +++++++++++++++
 tb/tb_spc_stack_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spc_pkg.sv
// -----------------------------------------------------------------------------
// spc_pkg
// Shared sizes, FSM state encoding and request struct for the SPC
// (subroutine return) stack controller.
// -----------------------------------------------------------------------------
package spc_pkg;

   localparam int SPC_WIDTH      = 19;
   localparam int SPC_DEPTH_LOG2 = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WSETUP  = 3'd1,
      WSTROBE = 3'd2,
      WHOLD   = 3'd3,
      RDLAT   = 3'd4
   } spc_state_e;

   // Requests as seen by the controller once qualified by IDLE.
   // push and pop both set means "replace top".
   typedef struct packed {
      logic push;
      logic pop;
   } spc_req_t;

endpackage

// File: rtl/spc_ptr.sv
// -----------------------------------------------------------------------------
// spc_ptr
// Wrapping up/down stack pointer. inc and dec together leave the pointer
// unchanged (replace-top). wrap_up / wrap_dn flag a step past either end.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   inc, dec        step requests (already qualified by the caller)
//   ptr             registered pointer
//   ptr_nxt         value ptr takes at the next edge
//   wrap_up         increment accepted at all-ones
//   wrap_dn         decrement accepted at zero
// -----------------------------------------------------------------------------
module spc_ptr
   import spc_pkg::*;
#(
   parameter int W = SPC_DEPTH_LOG2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] ptr,
   output logic [W-1:0] ptr_nxt,
   output logic         wrap_up,
   output logic         wrap_dn
);

   always_comb begin
      ptr_nxt = ptr;
      if (inc && !dec)
         ptr_nxt = ptr + W'(1);
      else if (dec && !inc)
         ptr_nxt = ptr - W'(1);
   end

   assign wrap_up = inc && !dec && (&ptr);
   assign wrap_dn = dec && !inc && !(|ptr);

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else
         ptr <= ptr_nxt;
   end

endmodule

// File: rtl/spc_stack_ctrl.sv
// -----------------------------------------------------------------------------
// spc_stack_ctrl
// Pointer and strobe controller for the 32-entry SPC stack built from
// 82S21 32x2 RAMs. Top of stack is ram[ptr]; push pre-increments, pop
// post-decrements. Pushes/replaces run WSETUP -> WSTROBE -> WHOLD so WE_N is
// low for exactly one cycle with address and data stable on both sides.
// Pops load the new top through the RAM output latch in RDLAT.
// Every RAM pin and status output is a flop.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, pop, wdata      requests from the microsequencer (ignored when busy)
//   ram_d                 RAM bank read data
//   ram_a, ram_i          RAM address / write data
//   ram_we_n, ram_latch_n RAM write strobe / output latch (low = hold)
//   ram_ce                RAM chip enable
//   top, ptr              registered top-of-stack and stack pointer
//   busy                  sequence in progress
//   ovf, unf              sticky wrap flags
//
// Build option: define SPC_OVF_TRAP_EN to enable the sticky ovf/unf flags;
// without it both outputs are constant 0.
// -----------------------------------------------------------------------------
module spc_stack_ctrl
   import spc_pkg::*;
#(
   parameter int WIDTH      = SPC_WIDTH,
   parameter int DEPTH_LOG2 = SPC_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH-1:0]      ram_d,
   output logic [DEPTH_LOG2-1:0] ram_a,
   output logic [WIDTH-1:0]      ram_i,
   output logic                  ram_we_n,
   output logic                  ram_latch_n,
   output logic                  ram_ce,
   output logic [WIDTH-1:0]      top,
   output logic [DEPTH_LOG2-1:0] ptr,
   output logic                  busy,
   output logic                  ovf,
   output logic                  unf
);

   spc_state_e            state, state_nxt;
   spc_req_t              req;
   logic [DEPTH_LOG2-1:0] ptr_nxt;
   logic                  wrap_up, wrap_dn;

   logic [DEPTH_LOG2-1:0] a_nxt;
   logic [WIDTH-1:0]      i_nxt, top_nxt;
   logic                  we_n_nxt, latch_n_nxt;

   always_comb begin
      req.push = (state == IDLE) && push;
      req.pop  = (state == IDLE) && pop;
   end

   // Push and pop together cancel in the pointer: replace-top.
   spc_ptr #(.W(DEPTH_LOG2)) u_ptr (
      .clk     (clk),
      .reset   (reset),
      .inc     (req.push),
      .dec     (req.pop),
      .ptr     (ptr),
      .ptr_nxt (ptr_nxt),
      .wrap_up (wrap_up),
      .wrap_dn (wrap_dn)
   );

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ---- next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req.push)     state_nxt = WSETUP;
                  else if (req.pop) state_nxt = RDLAT;
         WSETUP:  state_nxt = WSTROBE;
         WSTROBE: state_nxt = WHOLD;
         WHOLD:   state_nxt = IDLE;
         RDLAT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- outputs: next values of the pin registers ----
   always_comb begin
      a_nxt       = ram_a;
      i_nxt       = ram_i;
      top_nxt     = top;
      we_n_nxt    = 1'b1;
      latch_n_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (req.push) begin
               // ptr_nxt is ptr+1 for a push, ptr for a replace.
               a_nxt   = ptr_nxt;
               i_nxt   = wdata;
               top_nxt = wdata;           // bypass, RAM catches up later
            end else if (req.pop) begin
               a_nxt       = ptr_nxt;
               latch_n_nxt = 1'b1;        // let the new top flow through
            end
         end
         WSETUP:  we_n_nxt = 1'b0;        // strobe low while in WSTROBE
         RDLAT:   top_nxt  = ram_d;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ram_a       <= '0;
         ram_i       <= '0;
         ram_we_n    <= 1'b1;
         ram_latch_n <= 1'b1;
         ram_ce      <= 1'b0;
         top         <= '0;
         busy        <= 1'b0;
      end else begin
         ram_a       <= a_nxt;
         ram_i       <= i_nxt;
         ram_we_n    <= we_n_nxt;
         ram_latch_n <= latch_n_nxt;
         ram_ce      <= 1'b1;
         top         <= top_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

`ifdef SPC_OVF_TRAP_EN
   // Sticky; the pointer itself still wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (wrap_up) ovf <= 1'b1;
         if (wrap_dn) unf <= 1'b1;
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap_up ^ wrap_dn;
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_spc_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spc_stack_ctrl
// Directed bench for spc_stack_ctrl with a bench-side 82S21 bank model and a
// transaction-level reference model checked on every negedge after reset.
// -----------------------------------------------------------------------------
module tb_spc_stack_ctrl;

   localparam int W = 19;

   logic         clk = 1'b0;
   logic         reset, push, pop;
   logic [W-1:0] wdata, ram_d, ram_i, top;
   logic [4:0]   ram_a, ptr;
   logic         ram_we_n, ram_latch_n, ram_ce, busy, ovf, unf;

   int n_tests = 0;
   int n_fail  = 0;
   int we_cnt  = 0;

   always #5 clk = ~clk;

   spc_stack_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .pop         (pop),
      .wdata       (wdata),
      .ram_d       (ram_d),
      .ram_a       (ram_a),
      .ram_i       (ram_i),
      .ram_we_n    (ram_we_n),
      .ram_latch_n (ram_latch_n),
      .ram_ce      (ram_ce),
      .top         (top),
      .ptr         (ptr),
      .busy        (busy),
      .ovf         (ovf),
      .unf         (unf)
   );

   // ---- RAM bank: asynchronous read, write on an edge seen with WE_N low ----
   logic [W-1:0] ram_mem [32];
   initial for (int k = 0; k < 32; k++) ram_mem[k] = '0;
   assign ram_d = ram_mem[ram_a];
   always @(posedge clk)
      if (ram_we_n === 1'b0) ram_mem[ram_a] <= ram_i;

   always @(negedge clk)
      if (ram_we_n === 1'b0) we_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- reference model: counts down the busy cycles of each transaction ----
   int           m_ptr = 0, m_left = 0;
   bit           m_wr = 0, m_valid = 0;
   bit           m_we_n, m_latch_n, m_ce, m_ovf, m_unf;
   logic [W-1:0] m_top, m_i;
   int           m_a;
   logic [W-1:0] m_mem [32];
   initial for (int k = 0; k < 32; k++) m_mem[k] = '0;

   always @(posedge clk) begin
      if (reset === 1'b1) begin
         m_ptr = 0; m_left = 0; m_top = '0; m_a = 0; m_i = '0;
         m_we_n = 1; m_latch_n = 1; m_ce = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
      end else if (m_valid) begin
         m_ce = 1;
         m_latch_n = 0;
         if (m_left > 0) begin
            m_left--;
            if (!m_wr) m_top = m_mem[m_a];
         end else if (push || pop) begin
            if (push) begin
               m_wr = 1; m_left = 3;
               if (!pop) begin
`ifdef SPC_OVF_TRAP_EN
                  if (m_ptr == 31) m_ovf = 1;
`endif
                  m_ptr = (m_ptr + 1) % 32;
               end
               m_a = m_ptr; m_i = wdata; m_top = wdata; m_mem[m_ptr] = wdata;
            end else begin
               m_wr = 0; m_left = 1;
`ifdef SPC_OVF_TRAP_EN
               if (m_ptr == 0) m_unf = 1;
`endif
               m_ptr = (m_ptr + 31) % 32;
               m_a = m_ptr; m_latch_n = 1;
            end
         end
         // the write strobe is the middle of the three write cycles
         m_we_n = !(m_wr && m_left == 2);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_ptr",     32'(ptr),         32'(m_ptr));
         chk("m_ram_a",   32'(ram_a),       32'(m_a));
         chk("m_ram_i",   32'(ram_i),       32'(m_i));
         chk("m_top",     32'(top),         32'(m_top));
         chk("m_we_n",    32'(ram_we_n),    32'(m_we_n));
         chk("m_latch_n", 32'(ram_latch_n), 32'(m_latch_n));
         chk("m_ce",      32'(ram_ce),      32'(m_ce));
         chk("m_busy",    32'(busy),        32'(m_left > 0));
         chk("m_ovf",     32'(ovf),         32'(m_ovf));
         chk("m_unf",     32'(unf),         32'(m_unf));
      end
   end

   // ---- stimulus helpers ----
   task automatic req(input logic p, input logic q, input logic [W-1:0] d);
      push = p; pop = q; wdata = d;
      @(posedge clk); #2;
      push = 0; pop = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clk); #2;
      reset = 0;
   endtask

   logic [W-1:0] exp_flag;
   int we0;

   initial begin
      push = 0; pop = 0; wdata = '0; reset = 1;
      repeat (2) @(posedge clk);
      #2 reset = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_ptr",     32'(ptr),         32'd0);
      chk("rst_we_n",    32'(ram_we_n),    32'd1);
      chk("rst_latch_n", 32'(ram_latch_n), 32'd0);
      chk("rst_ce",      32'(ram_ce),      32'd1);
      chk("rst_busy",    32'(busy),        32'd0);
      chk("rst_top",     32'(top),         32'd0);

      // single push from ptr 0
      we0 = we_cnt;
      req(1, 0, 19'h12345);
      @(negedge clk);
      chk("push_ptr",   32'(ptr),   32'd1);
      chk("push_a",     32'(ram_a), 32'd1);
      chk("push_i",     32'(ram_i), 32'h12345);
      chk("push_top",   32'(top),   32'h12345);
      chk("model_top",  32'(m_top), 32'h12345);
      chk("push_c2_we", 32'(ram_we_n), 32'd1);
      chk("push_c2_bz", 32'(busy),     32'd1);
      @(negedge clk);
      chk("push_c3_we", 32'(ram_we_n), 32'd0);
      chk("push_c3_bz", 32'(busy),     32'd1);
      @(negedge clk);
      chk("push_c4_we", 32'(ram_we_n), 32'd1);
      chk("push_c4_bz", 32'(busy),     32'd1);
      @(negedge clk);
      chk("push_c5_bz", 32'(busy),     32'd0);
      chk("push_we_pulses", 32'(we_cnt - we0), 32'd1);
      chk("push_ram1",  32'(ram_mem[1]), 32'h12345);

      // push 1, push 2, pop
      do_reset();
      req(1, 0, 19'h00001); wait_idle();
      chk("p1_ptr", 32'(ptr), 32'd1);
      req(1, 0, 19'h00002); wait_idle();
      chk("p2_ptr", 32'(ptr), 32'd2);
      chk("p2_top", 32'(top), 32'h2);
      req(0, 1, '0);
      @(negedge clk);
      chk("pop_ptr",     32'(ptr),         32'd1);
      chk("pop_a",       32'(ram_a),       32'd1);
      chk("pop_latch_n", 32'(ram_latch_n), 32'd1);
      chk("pop_busy",    32'(busy),        32'd1);
      @(negedge clk);
      chk("pop_top",     32'(top),         32'h1);
      chk("model_pop",   32'(m_top),       32'h1);
      chk("pop_latch2",  32'(ram_latch_n), 32'd0);
      chk("pop_busy2",   32'(busy),        32'd0);

      // replace-top at ptr 3
      req(1, 0, 19'h00033); wait_idle();
      req(1, 0, 19'h00044); wait_idle();
      chk("rep_pre_ptr", 32'(ptr), 32'd3);
      we0 = we_cnt;
      req(1, 1, 19'h7FFFF);
      @(negedge clk);
      chk("rep_ptr", 32'(ptr),   32'd3);
      chk("rep_a",   32'(ram_a), 32'd3);
      chk("rep_top", 32'(top),   32'h7FFFF);
      wait_idle();
      chk("rep_we_pulses", 32'(we_cnt - we0), 32'd1);
      chk("rep_ram3",      32'(ram_mem[3]),   32'h7FFFF);
      req(0, 1, '0); wait_idle();
      chk("rep_pop_ptr", 32'(ptr), 32'd2);
      chk("rep_pop_top", 32'(top), 32'h33);

      // 32 pushes wrap the pointer, then pop from 0
      do_reset();
      for (int i = 0; i < 32; i++) begin
         req(1, 0, W'(32'h100 + i));
         wait_idle();
      end
      chk("wrap_ptr", 32'(ptr), 32'd0);
`ifdef SPC_OVF_TRAP_EN
      exp_flag = 1;
`else
      exp_flag = 0;
`endif
      chk("wrap_ovf", 32'(ovf), 32'(exp_flag));
      chk("wrap_unf_pre", 32'(unf), 32'd0);
      req(0, 1, '0); wait_idle();
      chk("wrap_pop_ptr", 32'(ptr), 32'd31);
      chk("wrap_pop_top", 32'(top), 32'h11E);
      // a pop accepted at ptr=0 is an underflow
      chk("wrap_unf", 32'(unf), 32'(exp_flag));
      chk("wrap_ovf_hold", 32'(ovf), 32'(exp_flag));

      // reset during WSTROBE, then a push ignored while busy
      do_reset();
      req(1, 0, 19'h00555);
      @(posedge clk); #2;
      reset = 1;
      @(negedge clk);
      chk("mid_we_low", 32'(ram_we_n), 32'd0);
      @(posedge clk); #2;
      reset = 0;
      @(negedge clk);
      chk("mid_we_n", 32'(ram_we_n), 32'd1);
      chk("mid_busy", 32'(busy),     32'd0);
      chk("mid_ptr",  32'(ptr),      32'd0);
      chk("mid_ovf",  32'(ovf),      32'd0);
      req(1, 0, 19'h00001);
      @(negedge clk);
      chk("ign_busy", 32'(busy), 32'd1);
      req(1, 0, 19'h00002);
      wait_idle();
      chk("ign_ptr", 32'(ptr), 32'd1);
      chk("ign_top", 32'(top), 32'h1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
